// File: rtl/slow_cycle_term_pkg.sv
// rtl/slow_cycle_term_pkg.sv - shared states, DSACK encodings and counter widths for slow_cycle_term
package slow_cycle_term_pkg;

    // Terminator FSM states
    typedef enum logic [2:0] {
        IDLE,
        WAIT_INT,
        WAIT_EXT,
        ACK,
        ERR,
        DONE
    } state_t;

    // Active-low 030 port-size acknowledge encodings
    localparam logic [1:0] DSACK_NONE = 2'b11;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_32   = 2'b00;

    // Wait-state counter holds 0..15, timeout counter holds 0..255
    localparam int CNT_W = 4;
    localparam int TMO_W = 8;

endpackage

// File: rtl/slow_cycle_term_sync2.sv
// rtl/slow_cycle_term_sync2.sv - generic 2-flop synchronizer, resets to 1
module sync2 (
    input  logic CLKCPU,
    input  logic RESET,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two back-to-back flops; output lags the pin by two edges
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/slow_cycle_term.sv
// rtl/slow_cycle_term.sv - DSACK/BERR bus-cycle terminator, optional timeout via SLOWCYCLE_BERR_TIMEOUT_EN
module slow_cycle_term
    import slow_cycle_term_pkg::*;
#(
    parameter int WAIT_READ  = 2,
    parameter int WAIT_WRITE = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       AS20,
    input  logic       RW20,
    input  logic       SLOWCYCLE,
    input  logic       INTCYCLE,
    input  logic       DTACK,
    output logic [1:0] DSACK,
    output logic       BERR,
    output logic       BUSY
);

    localparam logic [CNT_W-1:0] CNT_RD = CNT_W'(WAIT_READ);
    localparam logic [CNT_W-1:0] CNT_WR = CNT_W'(WAIT_WRITE);

    // Reject parameter values the counters cannot represent
    if (WAIT_READ < 0 || WAIT_READ > 15 || WAIT_WRITE < 0 || WAIT_WRITE > 15 ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("slow_cycle_term: parameter out of range");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dtack_s;
    logic             tmo_hit;

    sync2 u_dtack_sync (
        .CLKCPU (CLKCPU),
        .RESET  (RESET),
        .din    (DTACK),
        .dout   (dtack_s)
    );

`ifdef SLOWCYCLE_BERR_TIMEOUT_EN
    logic [TMO_W-1:0] tmo, tmo_n;

    assign tmo_hit = (tmo == TMO_W'(TIMEOUT));

    // Timeout counter: cleared while idle, counts every waiting cycle
    always_comb begin
        tmo_n = tmo;
        if (state == IDLE) begin
            tmo_n = '0;
        end else if ((state == WAIT_INT || state == WAIT_EXT) && !tmo_hit) begin
            tmo_n = tmo + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            tmo <= '0;
        end else begin
            tmo <= tmo_n;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state logic; an AS20 high sample always wins, then timeout, then termination
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (!AS20) begin
                    if (!INTCYCLE) begin
                        state_n = DONE;
                    end else if (!SLOWCYCLE) begin
                        state_n = WAIT_INT;
                        cnt_n   = RW20 ? CNT_RD : CNT_WR;
                    end else begin
                        state_n = WAIT_EXT;
                    end
                end
            end
            WAIT_INT: begin
                if (AS20) begin
                    state_n = IDLE;
                end else if (tmo_hit) begin
                    state_n = ERR;
                end else if (cnt == '0) begin
                    state_n = ACK;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WAIT_EXT: begin
                if (AS20) begin
                    state_n = IDLE;
                end else if (tmo_hit) begin
                    state_n = ERR;
                end else if (!dtack_s) begin
                    state_n = ACK;
                end
            end
            ACK, ERR, DONE: begin
                if (AS20) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counter and registered outputs decoded from the next state
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            DSACK <= DSACK_NONE;
            BERR  <= 1'b1;
            BUSY  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            DSACK <= (state_n == ACK) ? DSACK_16 : DSACK_NONE;
            BERR  <= (state_n != ERR);
            BUSY  <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_slow_cycle_term.sv
// tb/tb_slow_cycle_term.sv - self-checking bench for slow_cycle_term
module tb_slow_cycle_term;

    localparam int TMO_P = 16;
    localparam int WR0   = 2;
    localparam int WW0   = 1;
    localparam int WR1   = 15;
    localparam int WW1   = 0;
    localparam int INF   = 1 << 30;
`ifdef SLOWCYCLE_BERR_TIMEOUT_EN
    localparam int ERR_EDGE = TMO_P + 1;
`else
    localparam int ERR_EDGE = INF;
`endif
    localparam int K_INT  = 0;
    localparam int K_SLOW = 1;
    localparam int K_EXT  = 2;

    logic       clk = 1'b0;
    logic       reset, as20, rw20, slowc, intc, dtack;
    logic [1:0] dsack0, dsack1;
    logic       berr0, berr1, busy0, busy1;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    slow_cycle_term #(.WAIT_READ(WR0), .WAIT_WRITE(WW0), .TIMEOUT(TMO_P)) u_dut0 (
        .CLKCPU(clk), .RESET(reset), .AS20(as20), .RW20(rw20), .SLOWCYCLE(slowc),
        .INTCYCLE(intc), .DTACK(dtack), .DSACK(dsack0), .BERR(berr0), .BUSY(busy0)
    );

    slow_cycle_term #(.WAIT_READ(WR1), .WAIT_WRITE(WW1), .TIMEOUT(TMO_P)) u_dut1 (
        .CLKCPU(clk), .RESET(reset), .AS20(as20), .RW20(rw20), .SLOWCYCLE(slowc),
        .INTCYCLE(intc), .DTACK(dtack), .DSACK(dsack1), .BERR(berr1), .BUSY(busy1)
    );

    // Expected outputs after edge e of a cycle released at edge r, acks at a0/a1, bus errors at x0/x1
    task automatic check_edge(input string tag, input int e, input int r,
                              input int a0, input int a1, input int x0, input int x1);
        logic [1:0] ed0, ed1;
        logic       eb0, eb1, ebusy;
        ed0   = (e >= a0 && e < r) ? 2'b01 : 2'b11;
        ed1   = (e >= a1 && e < r) ? 2'b01 : 2'b11;
        eb0   = !(e >= x0 && e < r);
        eb1   = !(e >= x1 && e < r);
        ebusy = (e < r);
        checks++;
        assert (dsack0 === ed0) else begin
            failures++;
            $error("FAIL %s dsack0 edge=%0d observed=%b expected=%b", tag, e, dsack0, ed0);
        end
        checks++;
        assert (dsack1 === ed1) else begin
            failures++;
            $error("FAIL %s dsack1 edge=%0d observed=%b expected=%b", tag, e, dsack1, ed1);
        end
        checks++;
        assert (berr0 === eb0) else begin
            failures++;
            $error("FAIL %s berr0 edge=%0d observed=%b expected=%b", tag, e, berr0, eb0);
        end
        checks++;
        assert (berr1 === eb1) else begin
            failures++;
            $error("FAIL %s berr1 edge=%0d observed=%b expected=%b", tag, e, berr1, eb1);
        end
        checks++;
        assert (busy0 === ebusy) else begin
            failures++;
            $error("FAIL %s busy0 edge=%0d observed=%b expected=%b", tag, e, busy0, ebusy);
        end
        checks++;
        assert (busy1 === ebusy) else begin
            failures++;
            $error("FAIL %s busy1 edge=%0d observed=%b expected=%b", tag, e, busy1, ebusy);
        end
    endtask

    // Idle gap with AS20 and DTACK high, outputs checked inactive every cycle
    task automatic idle_gap(input string tag);
        as20  = 1'b1;
        dtack = 1'b1;
        intc  = 1'b1;
        slowc = 1'b1;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            check_edge(tag, 0, 0, INF, INF, INF, INF);
        end
    endtask

    // One bus cycle: AS20 low sampled at edge 0, high sampled at edge r.
    // External cycles see DTACK low at the pin for edges d .. d+dlen-1 (d<0: never).
    task automatic run_txn(input string tag, input int kind, input logic rw,
                           input int r, input int d, input int dlen);
        int a0, a1, x0, x1;
        a0 = INF; a1 = INF; x0 = INF; x1 = INF;
        if (kind == K_SLOW) begin
            a0 = 1 + (rw ? WR0 : WW0);
            a1 = 1 + (rw ? WR1 : WW1);
        end else if (kind == K_EXT && d >= 0) begin
            a0 = d + 2;
            a1 = d + 2;
        end
        if (kind != K_INT) begin
            if (ERR_EDGE <= a0) begin x0 = ERR_EDGE; a0 = INF; end
            if (ERR_EDGE <= a1) begin x1 = ERR_EDGE; a1 = INF; end
        end
        as20  = 1'b0;
        rw20  = rw;
        intc  = (kind == K_INT) ? 1'b0 : 1'b1;
        slowc = (kind == K_SLOW) ? 1'b0 : (kind == K_EXT) ? 1'b1 : 1'($urandom_range(0, 1));
        dtack = (kind == K_EXT) ? !(d == 0 && dlen > 0) : 1'($urandom_range(0, 1));
        for (int e = 0; e <= r; e++) begin
            @(negedge clk);
            check_edge(tag, e, r, a0, a1, x0, x1);
            as20  = (e + 1 >= r);
            rw20  = 1'($urandom_range(0, 1));
            slowc = 1'($urandom_range(0, 1));
            intc  = 1'($urandom_range(0, 1));
            if (e + 1 > r)
                dtack = 1'b1;
            else if (kind == K_EXT)
                dtack = !(d >= 0 && e + 1 >= d && e + 1 < d + dlen);
            else
                dtack = 1'($urandom_range(0, 1));
        end
        idle_gap(tag);
    endtask

    initial begin
        reset = 1'b1;
        as20  = 1'b1;
        rw20  = 1'b1;
        slowc = 1'b1;
        intc  = 1'b1;
        dtack = 1'b1;
        repeat (3) @(negedge clk);
        check_edge("reset", 0, 0, INF, INF, INF, INF);
        reset = 1'b0;
        idle_gap("post_reset");

        run_txn("slow_read",  K_SLOW, 1'b1, 6,  -1, 0);
        run_txn("slow_write", K_SLOW, 1'b0, 5,  -1, 0);
        run_txn("slow_abort", K_SLOW, 1'b1, 3,  -1, 0);
        run_txn("int_cycle",  K_INT,  1'b1, 10, -1, 0);
        run_txn("ext_bounce", K_EXT,  1'b1, 12, 4,  1);
        run_txn("ext_hold",   K_EXT,  1'b0, 9,  4,  20);
        run_txn("ext_abort",  K_EXT,  1'b1, 3,  -1, 0);
        run_txn("ext_none",   K_EXT,  1'b1, 1000, -1, 0);

        // Reset during a slow read wait
        as20  = 1'b0;
        intc  = 1'b1;
        slowc = 1'b0;
        rw20  = 1'b1;
        dtack = 1'b1;
        @(negedge clk);
        check_edge("rst_wait", 0, INF, 1 + WR0, 1 + WR1, INF, INF);
        @(negedge clk);
        check_edge("rst_wait", 1, INF, 1 + WR0, 1 + WR1, INF, INF);
        reset = 1'b1;
        @(negedge clk);
        check_edge("rst_hit", 0, 0, INF, INF, INF, INF);
        reset = 1'b0;
        idle_gap("rst_release");

        for (int i = 0; i < 60; i++) begin
            int   kind, r, d, dlen;
            logic rw;
            kind = $urandom_range(0, 2);
            rw   = 1'($urandom_range(0, 1));
            r    = $urandom_range(1, 24);
            d    = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 12);
            dlen = $urandom_range(1, 30);
            run_txn("random", kind, rw, r, d, dlen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
